// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio-path types and constants
package audio_pkg;

  localparam int FREQ_W         = 13;
  localparam int CLK_HZ_DEFAULT = 50_000_000;

  typedef logic [FREQ_W-1:0]  freq_t;
  typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/tone_generator_if.sv
// rtl/tone_generator_if.sv - control/output bundle of the tone generator (vol lane under TONE_VOLUME_EN)
interface tone_generator_if #(
  parameter int AMP_W = 16
);
  import audio_pkg::*;

  logic                    enable;
  freq_t                   freq;
  logic                    freq_load;
`ifdef TONE_VOLUME_EN
  logic [2:0]              vol;
`endif
  logic                    pending;
  logic                    square_out;
  logic                    edge_stb;
  logic signed [AMP_W-1:0] sample_out;

`ifdef TONE_VOLUME_EN
  modport master (output enable, freq, freq_load, vol,
                  input  pending, square_out, edge_stb, sample_out);
  modport slave  (input  enable, freq, freq_load, vol,
                  output pending, square_out, edge_stb, sample_out);
`else
  modport master (output enable, freq, freq_load,
                  input  pending, square_out, edge_stb, sample_out);
  modport slave  (input  enable, freq, freq_load,
                  output pending, square_out, edge_stb, sample_out);
`endif

endinterface

// File: rtl/tone_nco_core.sv
// rtl/tone_nco_core.sv - fractional accumulator that toggles a square wave at 2*freq per CLK_HZ cycles
module tone_nco_core #(
  parameter int CLK_HZ = audio_pkg::CLK_HZ_DEFAULT,
  parameter int ACC_W  = $clog2(CLK_HZ) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic [ACC_W-1:0] step_i,
  output logic             toggle_o,
  output logic             square_o,
  output logic             square_nxt_o
);

  localparam logic [ACC_W:0] CLK_C = (ACC_W + 1)'(CLK_HZ);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sq_q, sq_d;
  logic [ACC_W:0]   sum;
  logic             wrap;

  // One extra bit on the sum so acc + step can never overflow before the compare.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, step_i};
    wrap  = run_i && (sum >= CLK_C);
    acc_d = acc_q;
    sq_d  = sq_q;
    if (clr_i) begin
      acc_d = '0;
      sq_d  = 1'b0;
    end else if (run_i) begin
      if (wrap) begin
        // sum < 2*CLK_HZ, so the remainder fits back into ACC_W bits.
        acc_d = sum[ACC_W-1:0] - CLK_C[ACC_W-1:0];
        sq_d  = ~sq_q;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  // Accumulator and square-wave state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sq_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sq_q  <= sq_d;
    end
  end

  assign toggle_o     = wrap;
  assign square_o     = sq_q;
  assign square_nxt_o = sq_d;

endmodule

// File: rtl/tone_generator.sv
// rtl/tone_generator.sv - glitch-free square-wave tone synthesiser; TONE_VOLUME_EN adds a 3-bit volume input
module tone_generator
  import audio_pkg::*;
#(
  parameter int                      CLK_HZ    = CLK_HZ_DEFAULT,
  parameter int                      AMP_W     = 16,
  parameter logic signed [AMP_W-1:0] AMPLITUDE = 16'sd8192,
  localparam int                     ACC_W     = $clog2(CLK_HZ) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  tone_generator_if.slave bus
);

  freq_t                   cur_q, cur_d;
  freq_t                   pend_q, pend_d;
  logic                    pending_q, pending_d;
  logic                    edge_q, edge_d;
  logic signed [AMP_W-1:0] sample_q, sample_d;
  logic signed [AMP_W-1:0] mag;

  logic             active;
  logic             apply;
  logic             nco_clr;
  logic             nco_toggle;
  logic             nco_square;
  logic             nco_square_nxt;
  logic [ACC_W-1:0] nco_step;

  assign active   = bus.enable && (cur_q != '0);
  assign nco_step = ACC_W'({cur_q, 1'b0});

  tone_nco_core #(
    .CLK_HZ (CLK_HZ),
    .ACC_W  (ACC_W)
  ) u_nco (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_i        (active),
    .clr_i        (nco_clr),
    .step_i       (nco_step),
    .toggle_o     (nco_toggle),
    .square_o     (nco_square),
    .square_nxt_o (nco_square_nxt)
  );

`ifdef TONE_VOLUME_EN
  assign mag = AMPLITUDE >>> (3'd7 - bus.vol);
`else
  assign mag = AMPLITUDE;
`endif

  // Frequency hand-over: applied when idle, or only on a toggle edge while running.
  always_comb begin
    cur_d     = cur_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    apply     = pending_q && (!active || nco_toggle);
    nco_clr   = !active;
    if (apply) begin
      cur_d     = pend_q;
      pending_d = 1'b0;
      if (pend_q == '0) begin
        nco_clr = 1'b1;
      end
    end
    // A load on the apply edge is held for the next boundary, not merged into this one.
    if (bus.freq_load) begin
      pend_d    = bus.freq;
      pending_d = 1'b1;
    end
    edge_d   = nco_toggle && !nco_clr;
    sample_d = '0;
    if (bus.enable && (cur_d != '0)) begin
      sample_d = nco_square_nxt ? mag : -mag;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q     <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      edge_q    <= 1'b0;
      sample_q  <= '0;
    end else begin
      cur_q     <= cur_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      edge_q    <= edge_d;
      sample_q  <= sample_d;
    end
  end

  assign bus.pending    = pending_q;
  assign bus.square_out = nco_square;
  assign bus.edge_stb   = edge_q;
  assign bus.sample_out = sample_q;

endmodule

// File: tb/tb_tone_generator.sv
// tb/tb_tone_generator.sv - self-checking bench for tone_generator
module tb_tone_generator;
  import audio_pkg::*;

  localparam int CLK = 10_000;
  localparam int AMP = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  tone_generator_if #(.AMP_W(16)) bus ();

  tone_generator #(
    .CLK_HZ    (CLK),
    .AMP_W     (16),
    .AMPLITUDE (16'sd8192)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Ideal tone: after n active cycles at f Hz, floor(n*2f/CLK) half-periods have elapsed.
  function automatic int ref_toggles(int n, int f);
    return (n * 2 * f) / CLK;
  endfunction

  function automatic logic ref_edge(int n, int f);
    return ref_toggles(n, f) != ref_toggles(n - 1, f);
  endfunction

  function automatic logic ref_square(int n, int f);
    return ref_toggles(n, f) % 2 == 1;
  endfunction

  function automatic int ref_sample(int n, int f);
    return ref_square(n, f) ? AMP : -AMP;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Silence, load f while idle, apply it, then enable; the next tick is active cycle 1.
  task automatic start_tone(int f);
    bus.enable    = 1'b0;
    bus.freq      = freq_t'(f);
    bus.freq_load = 1'b1;
    tick();
    bus.freq_load = 1'b0;
    tick();
    bus.enable    = 1'b1;
  endtask

  task automatic test_reset();
    int s;
    s = bus.sample_out;
    n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL reset_pending: got %b expected 0", bus.pending); end
    n_cmp++; if (bus.square_out !== 1'b0) begin n_err++; $display("FAIL reset_square: got %b expected 0", bus.square_out); end
    n_cmp++; if (bus.edge_stb !== 1'b0) begin n_err++; $display("FAIL reset_edge: got %b expected 0", bus.edge_stb); end
    n_cmp++; if (s !== 0) begin n_err++; $display("FAIL reset_sample: got %0d expected 0", s); end
    bus.enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++; if (bus.edge_stb !== 1'b0) begin n_err++; $display("FAIL reset_silent_edge: cycle %0d got %b expected 0", i, bus.edge_stb); end
    end
  endtask

  task automatic test_basic();
    int s;
    bus.enable    = 1'b1;
    bus.freq      = freq_t'(1000);
    bus.freq_load = 1'b1;
    tick();
    n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL basic_pending_set: got %b expected 1", bus.pending); end
    bus.freq_load = 1'b0;
    tick();
    n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL basic_pending_clr: got %b expected 0", bus.pending); end
    for (int n = 1; n <= 40; n++) begin
      tick();
      s = bus.sample_out;
      n_cmp++; if (bus.edge_stb !== ref_edge(n, 1000)) begin n_err++; $display("FAIL basic_edge: n=%0d got %b expected %b", n, bus.edge_stb, ref_edge(n, 1000)); end
      n_cmp++; if (bus.square_out !== ref_square(n, 1000)) begin n_err++; $display("FAIL basic_square: n=%0d got %b expected %b", n, bus.square_out, ref_square(n, 1000)); end
      n_cmp++; if (s !== ref_sample(n, 1000)) begin n_err++; $display("FAIL basic_sample: n=%0d got %0d expected %0d", n, s, ref_sample(n, 1000)); end
    end
  endtask

  task automatic test_count_3000();
    int cnt;
    logic exp_e;
    cnt = 0;
    start_tone(3000);
    for (int n = 1; n <= 10_000; n++) begin
      tick();
      if (bus.edge_stb === 1'b1) cnt++;
      if (n <= 5) begin
        exp_e = (n == 2 || n == 4 || n == 5);
        n_cmp++; if (bus.edge_stb !== exp_e) begin n_err++; $display("FAIL f3000_first_edges: n=%0d got %b expected %b", n, bus.edge_stb, exp_e); end
      end
    end
    n_cmp++; if (cnt !== 6000) begin n_err++; $display("FAIL f3000_count: got %0d expected 6000", cnt); end
  endtask

  task automatic test_retune();
    int cnt;
    int last;
    int gap;
    start_tone(1000);
    repeat (5) tick();
    n_cmp++; if (bus.edge_stb !== 1'b1) begin n_err++; $display("FAIL retune_first_edge: got %b expected 1", bus.edge_stb); end
    tick();
    bus.freq      = freq_t'(2000);
    bus.freq_load = 1'b1;
    tick();
    bus.freq_load = 1'b0;
    n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL retune_pending_set: got %b expected 1", bus.pending); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (bus.pending !== 1'b1 || bus.edge_stb !== 1'b0) begin n_err++; $display("FAIL retune_wait: i=%0d got pending=%b edge=%b expected pending=1 edge=0", i, bus.pending, bus.edge_stb); end
    end
    tick();
    n_cmp++; if (bus.pending !== 1'b0 || bus.edge_stb !== 1'b1) begin n_err++; $display("FAIL retune_switch: got pending=%b edge=%b expected pending=0 edge=1", bus.pending, bus.edge_stb); end
    cnt  = 0;
    last = 0;
    for (int i = 1; i <= 10_000; i++) begin
      tick();
      if (bus.edge_stb === 1'b1) begin
        gap = i - last;
        n_cmp++; if (!(gap == 2 || gap == 3)) begin n_err++; $display("FAIL retune_gap: got %0d expected 2 or 3", gap); end
        last = i;
        cnt++;
      end
    end
    n_cmp++; if (cnt !== 4000) begin n_err++; $display("FAIL retune_count: got %0d expected 4000", cnt); end
  endtask

  task automatic test_load_on_toggle();
    logic exp_e;
    start_tone(1000);
    repeat (4) tick();
    bus.freq      = freq_t'(3000);
    bus.freq_load = 1'b1;
    tick();
    bus.freq_load = 1'b0;
    n_cmp++; if (bus.edge_stb !== 1'b1 || bus.pending !== 1'b1) begin n_err++; $display("FAIL coincide_edge: got edge=%b pending=%b expected edge=1 pending=1", bus.edge_stb, bus.pending); end
    for (int n = 6; n <= 9; n++) begin
      tick();
      n_cmp++; if (bus.edge_stb !== 1'b0 || bus.pending !== 1'b1) begin n_err++; $display("FAIL coincide_old_half: n=%0d got edge=%b pending=%b expected edge=0 pending=1", n, bus.edge_stb, bus.pending); end
    end
    tick();
    n_cmp++; if (bus.edge_stb !== 1'b1 || bus.pending !== 1'b0) begin n_err++; $display("FAIL coincide_switch: got edge=%b pending=%b expected edge=1 pending=0", bus.edge_stb, bus.pending); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_e = ref_edge(i, 3000);
      n_cmp++; if (bus.edge_stb !== exp_e) begin n_err++; $display("FAIL coincide_new_rate: i=%0d got %b expected %b", i, bus.edge_stb, exp_e); end
    end
  endtask

  task automatic test_enable_drop();
    int s;
    start_tone(1000);
    repeat (7) tick();
    bus.enable = 1'b0;
    tick();
    s = bus.sample_out;
    n_cmp++; if (bus.square_out !== 1'b0) begin n_err++; $display("FAIL drop_square: got %b expected 0", bus.square_out); end
    n_cmp++; if (s !== 0) begin n_err++; $display("FAIL drop_sample: got %0d expected 0", s); end
    n_cmp++; if (bus.edge_stb !== 1'b0) begin n_err++; $display("FAIL drop_edge: got %b expected 0", bus.edge_stb); end
    repeat (3) tick();
    bus.enable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++; if (bus.edge_stb !== (i == 5)) begin n_err++; $display("FAIL reenable_edge: i=%0d got %b expected %b", i, bus.edge_stb, (i == 5)); end
      if (i == 1) begin
        s = bus.sample_out;
        n_cmp++; if (s !== -AMP) begin n_err++; $display("FAIL reenable_sample: got %0d expected %0d", s, -AMP); end
      end
    end
  endtask

  task automatic test_zero_apply();
    int s;
    int cnt;
    start_tone(1000);
    repeat (2) tick();
    bus.freq      = '0;
    bus.freq_load = 1'b1;
    tick();
    bus.freq_load = 1'b0;
    n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL zero_pending_set: got %b expected 1", bus.pending); end
    repeat (2) tick();
    s = bus.sample_out;
    n_cmp++; if (bus.square_out !== 1'b0 || bus.pending !== 1'b0) begin n_err++; $display("FAIL zero_apply: got square=%b pending=%b expected 0 0", bus.square_out, bus.pending); end
    n_cmp++; if (s !== 0) begin n_err++; $display("FAIL zero_sample: got %0d expected 0", s); end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.edge_stb !== 1'b0 || bus.square_out !== 1'b0) cnt++;
    end
    n_cmp++; if (cnt !== 0) begin n_err++; $display("FAIL zero_silent: got %0d active cycles expected 0", cnt); end
  endtask

  task automatic test_async_reset();
    int s;
    start_tone(1000);
    repeat (7) tick();
    bus.freq      = freq_t'(2000);
    bus.freq_load = 1'b1;
    tick();
    bus.freq_load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    s = bus.sample_out;
    n_cmp++; if (bus.pending !== 1'b0 || bus.square_out !== 1'b0 || bus.edge_stb !== 1'b0) begin n_err++; $display("FAIL async_reset_bits: got pending=%b square=%b edge=%b expected 0 0 0", bus.pending, bus.square_out, bus.edge_stb); end
    n_cmp++; if (s !== 0) begin n_err++; $display("FAIL async_reset_sample: got %0d expected 0", s); end
    #3 rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_cmp++; if (bus.edge_stb !== 1'b0 || bus.square_out !== 1'b0) begin n_err++; $display("FAIL post_reset_silent: i=%0d got edge=%b square=%b expected 0 0", i, bus.edge_stb, bus.square_out); end
    end
  endtask

  task automatic test_random();
    int f;
    int len;
    int s;
    for (int r = 0; r < 6; r++) begin
      f   = $urandom_range(1, 4999);
      len = $urandom_range(50, 400);
      start_tone(f);
      for (int n = 1; n <= len; n++) begin
        tick();
        s = bus.sample_out;
        n_cmp++; if (bus.edge_stb !== ref_edge(n, f)) begin n_err++; $display("FAIL rand_edge: f=%0d n=%0d got %b expected %b", f, n, bus.edge_stb, ref_edge(n, f)); end
        n_cmp++; if (bus.square_out !== ref_square(n, f)) begin n_err++; $display("FAIL rand_square: f=%0d n=%0d got %b expected %b", f, n, bus.square_out, ref_square(n, f)); end
        n_cmp++; if (s !== ref_sample(n, f)) begin n_err++; $display("FAIL rand_sample: f=%0d n=%0d got %0d expected %0d", f, n, s, ref_sample(n, f)); end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time %0t reached without completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.enable    = 1'b0;
    bus.freq      = '0;
    bus.freq_load = 1'b0;
`ifdef TONE_VOLUME_EN
    bus.vol       = 3'd7;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_count_3000();
    test_retune();
    test_load_on_toggle();
    test_enable_drop();
    test_zero_apply();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tone_generator.md
Name: tone_generator

Overview:
- Downstream consumer of the note-to-frequency encoder: takes a 13-bit frequency in Hz and synthesises a square-wave tone for the audio output path.
- Uses a fractional (Bresenham-style) accumulator, so there is no divider and the average frequency is exact.
- Frequency changes are applied only at half-period boundaries, so the output never glitches mid-cycle.
- Output is a 1-bit square wave plus a signed sample for the DAC/PWM stage.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz. Must satisfy 2*8191 < CLK_HZ.
- AMP_W, 16, width of the signed sample output.
- AMPLITUDE, 16'sd8192, peak magnitude of sample_out. Must satisfy 0 < AMPLITUDE < 2^(AMP_W-1).
- ACC_W, $clog2(CLK_HZ)+1, accumulator width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  tone gate; low means silence.
- freq  in  13  requested frequency in Hz, unsigned; 0 means silence.
- freq_load  in  1  single-cycle strobe that captures freq.
- pending  out  1  a captured frequency is waiting to be applied.
- square_out  out  1  square wave.
- edge_stb  out  1  one-cycle pulse on every square_out toggle.
- sample_out  out  AMP_W  signed sample: +AMPLITUDE, -AMPLITUDE, or 0.

Behaviour:
- Reset (async assert, sync release): cur_freq=0, pend_freq=0, pending=0, acc=0, square_out=0, edge_stb=0, sample_out=0.
- Active means enable=1 and cur_freq!=0.
- Each active cycle:
  - sum = acc + 2*cur_freq, computed at ACC_W+1 bits with no overflow.
  - If sum >= CLK_HZ: acc <= sum - CLK_HZ, square_out toggles, edge_stb=1.
  - Otherwise: acc <= sum, edge_stb=0.
- Resulting toggle rate is exactly 2*cur_freq per CLK_HZ cycles, so output frequency equals cur_freq on average.
- freq_load:
  - pend_freq <= freq and pending <= 1 on the next edge.
  - A second load while pending overwrites pend_freq (last write wins).
- Apply rule:
  - If not active, pend_freq moves to cur_freq on the cycle after capture. At the same time acc <= 0, square_out <= 0, pending <= 0.
  - If active, pend_freq moves to cur_freq on the next cycle that toggles. acc keeps its remainder and the new value is used from the following cycle. pending clears on that same edge.
- Load in the same cycle as a toggle: the new value is not applied on that toggle. It is applied at the following toggle.
- Applying freq=0 while active: cur_freq=0. square_out <= 0 and acc <= 0 on the same edge.
- enable falling: on the next edge, square_out <= 0, acc <= 0, edge_stb <= 0. cur_freq is retained.
- enable rising: acc starts at 0 and square_out at 0, so the first toggle occurs after ceil(CLK_HZ/(2*cur_freq)) cycles.
- sample_out (registered, same edge as square_out):
  - not active: 0
  - square_out=1: +AMPLITUDE
  - square_out=0: -AMPLITUDE
- Latency: freq_load to pending=1 is 1 cycle. Idle apply completes 1 cycle after capture.

Optional Feature:
- Macro TONE_VOLUME_EN.
- Defined: adds input port vol [2:0]. Sample magnitude = AMPLITUDE >>> (7-vol), so vol=7 is full scale and vol=0 gives AMPLITUDE>>>7. vol is sampled every cycle; square_out is unaffected.
- Undefined: no vol port; magnitude is always AMPLITUDE.

Decomposition:
- Shared package audio_pkg holds:
  - FREQ_W=13 and typedef freq_t (logic [FREQ_W-1:0]).
  - Default CLK_HZ constant.
  - typedef sample_t (logic signed [15:0]).
- One natural sub-module, tone_nco_core: accumulator, compare/subtract and toggle. Inputs step and run; outputs toggle strobe.
- Load/pending/apply control and sample formatting stay in tone_generator.

Test Plan:
- CLK_HZ=10_000, load freq=1000, enable=1:
  - pending=1 for 1 cycle, then cleared.
  - edge_stb every 5 cycles; square_out period 10 cycles.
  - sample_out alternates +8192/-8192.
- CLK_HZ=10_000, freq=3000: over 10_000 active cycles, exactly 6000 edge_stb pulses; first toggles at cycles 2, 4, 5 after start.
- Running at 1000, load 2000 two cycles after a toggle:
  - pending stays 1 until the next toggle (3 cycles later).
  - Thereafter toggles occur every 2 or 3 cycles, averaging 4000 per 10_000 cycles.
- Load coincident with a toggle: the old frequency governs one more half-period; the switch happens at the next toggle.
- Drop enable mid-period: next cycle square_out=0, sample_out=0, edge_stb=0. Re-enable: first toggle 5 cycles later at freq=1000.
- Assert rst_n=0 asynchronously mid-tone: all outputs are 0 immediately. After release, no toggles occur until a freq_load.
